pipe_hazard_ctrl: RTL

//  Pipeline stall/flush controller for a NUM_STAGES-deep in-order core; generalised successor of the

---
 rtl/pipe_hazard_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// PipeHazardCtrl (top module pipe_hazard_ctrl)
//
// Purpose:
//    Stall/flush controller for a NUM_STAGES-deep in-order pipeline. It turns
//    cache stalls, branch redirects, jumps, multi-cycle-unit busy and ID
//    hazards into per-register write enables and bubble (flush) strobes.
//    A redirect or jump that arrives while memory is stalled is remembered
//    and applied on the first cycle after the stall. Saturating performance
//    counters and a sticky memory-stall watchdog are also provided.
//
// Ports:
//    clk           clock
//    rst           synchronous active-high reset
//    imem_stall_i  instruction cache miss stall
//    dmem_stall_i  data cache miss stall
//    redirect_i    mispredict / branch taken at REDIRECT_STAGE
//    jump_i        jump resolved at REDIRECT_STAGE
//    mdu_busy_i    multi-cycle unit in MDU_STAGE still working
//    ctrl_stall_i  branch/jump decoded in ID
//    load_use_i    load-use hazard detected in ID
//    cnt_clr_i     synchronous clear of the performance counters
//    write_o       per-register write enable (bit0 = PC)
//    flush_o       per-register flush / bubble insert (bit0 always 0)
//    cnt_mem_o     cycles with a memory stall
//    cnt_hazard_o  cycles stalled by mdu busy / ctrl stall / load-use
//    cnt_flush_o   cycles with a redirect/jump flush applied
//    timeout_o     sticky watchdog flag, cleared only by rst
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int NUM_STAGES     = 5,
    parameter int REDIRECT_STAGE = 2,
    parameter int HAZARD_STAGE   = 2,
    parameter int MDU_STAGE      = 2,
    parameter int BRPRED         = 0,
    parameter int CNT_W          = 32,
    parameter int TIMEOUT        = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  imem_stall_i,
    input  logic                  dmem_stall_i,
    input  logic                  redirect_i,
    input  logic                  jump_i,
    input  logic                  mdu_busy_i,
    input  logic                  ctrl_stall_i,
    input  logic                  load_use_i,
    input  logic                  cnt_clr_i,
    output logic [NUM_STAGES-1:0] write_o,
    output logic [NUM_STAGES-1:0] flush_o,
    output logic [CNT_W-1:0]      cnt_mem_o,
    output logic [CNT_W-1:0]      cnt_hazard_o,
    output logic [CNT_W-1:0]      cnt_flush_o,
    output logic                  timeout_o
);

    // The run-length counter saturates at TIMEOUT so it never wraps.
    localparam int              RUN_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(TIMEOUT);

    typedef enum logic {
        RUN,
        HOLD
    } stateT;

    stateT             stateQ;
    stateT             stateD;
    logic              memStall;
    logic              pendQ;
    logic              flushSel;
    logic              hazardSel;
    logic [RUN_W-1:0]  runQ;
    logic [CNT_W-1:0]  cntMemQ;
    logic [CNT_W-1:0]  cntHazardQ;
    logic [CNT_W-1:0]  cntFlushQ;
    logic              timeoutQ;

    assign memStall = imem_stall_i | dmem_stall_i;

    // State register: HOLD marks that the pipeline is frozen by memory.
    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ <= RUN;
        end else begin
            stateQ <= stateD;
        end
    end

    // Next-state logic for the memory hold tracker.
    always_comb begin
        stateD = stateQ;
        case (stateQ)
            RUN:     if (memStall)  stateD = HOLD;
            HOLD:    if (!memStall) stateD = RUN;
            default: stateD = RUN;
        endcase
    end

    // Pending redirect: captured during a stall, consumed on the first
    // released cycle. A fresh redirect in that same cycle folds into the
    // single flush instead of producing a second one.
    always_ff @(posedge clk) begin
        if (rst) begin
            pendQ <= 1'b0;
        end else if (memStall && (redirect_i || jump_i)) begin
            pendQ <= 1'b1;
        end else if (stateQ == HOLD && !memStall) begin
            pendQ <= 1'b0;
        end
    end

    // Priority encoder for write/flush enables; first matching cause wins.
    // Redirects and jumps share the same flush pattern.
    always_comb begin
        write_o   = '1;
        flush_o   = '0;
        flushSel  = 1'b0;
        hazardSel = 1'b0;
        if (memStall) begin
            write_o = '0;
        end else if (redirect_i || pendQ || jump_i) begin
            flushSel = 1'b1;
            for (int k = 1; k < NUM_STAGES; k++) begin
                if (k < REDIRECT_STAGE) flush_o[k] = 1'b1;
            end
        end else if (mdu_busy_i) begin
            hazardSel = 1'b1;
            for (int k = 0; k < NUM_STAGES; k++) begin
                if (k <= MDU_STAGE)    write_o[k] = 1'b0;
                if (k == MDU_STAGE + 1) flush_o[k] = 1'b1;
            end
        end else if (ctrl_stall_i) begin
            hazardSel  = 1'b1;
            flush_o[1] = 1'b1;
            write_o[0] = (BRPRED != 0);
        end else if (load_use_i) begin
            hazardSel = 1'b1;
            for (int k = 0; k < NUM_STAGES; k++) begin
                if (k < HAZARD_STAGE)  write_o[k] = 1'b0;
                if (k == HAZARD_STAGE && k > 0) flush_o[k] = 1'b1;
            end
        end
    end

    // Saturating performance counters; a clear beats a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr_i) begin
            cntMemQ    <= '0;
            cntHazardQ <= '0;
            cntFlushQ  <= '0;
        end else begin
            if (memStall && cntMemQ != '1)     cntMemQ    <= cntMemQ + CNT_W'(1);
            if (hazardSel && cntHazardQ != '1) cntHazardQ <= cntHazardQ + CNT_W'(1);
            if (flushSel && cntFlushQ != '1)   cntFlushQ  <= cntFlushQ + CNT_W'(1);
        end
    end

    // Watchdog: count consecutive memory-stall cycles; the flag is set one
    // cycle after the run reaches TIMEOUT and holds until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            runQ     <= '0;
            timeoutQ <= 1'b0;
        end else begin
            if (!memStall) begin
                runQ <= '0;
            end else if (runQ != RUN_MAX) begin
                runQ <= runQ + RUN_W'(1);
            end
            if (TIMEOUT != 0 && runQ == RUN_MAX) begin
                timeoutQ <= 1'b1;
            end
        end
    end

    assign cnt_mem_o    = cntMemQ;
    assign cnt_hazard_o = cntHazardQ;
    assign cnt_flush_o  = cntFlushQ;
    assign timeout_o    = timeoutQ;

endmodule
